nn_weight_loader: RTL and testbench

Byte-stream front end that programs the feed-forward network's weight memories. It accepts framed weight bytes over a valid/ready stream, checks a frame checksum, and drives the network's weight write port one word per accepted byte. It sits between the host link and the network top-level, and its outputs connect directly to that block's `weights_*` inputs.

---
 rtl/nn_pkg.sv | 36 +++
 rtl/nn_weight_loader_if.sv | 31 +++
 rtl/nn_weight_addr_counter.sv | 54 +++++
 rtl/nn_weight_loader.sv | 120 ++++++++++++
 tb/tb_nn_weight_loader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the feed-forward network and its weight loader:
// sync byte, loader state encoding and layer dimension helpers.
package nn_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int layer0_n(input int input_size, input int bias_size);
        return input_size + bias_size;
    endfunction

    function automatic int layer0_m(input int hidden_size);
        return hidden_size;
    endfunction

    function automatic int layer1_n(input int hidden_size, input int bias_size);
        return hidden_size + bias_size;
    endfunction

    function automatic int layer1_m(input int output_size);
        return output_size;
    endfunction

    function automatic int total_weights(input int input_size, input int hidden_size,
                                         input int output_size, input int bias_size);
        return layer0_n(input_size, bias_size) * layer0_m(hidden_size)
             + layer1_n(hidden_size, bias_size) * layer1_m(output_size);
    endfunction

endpackage

// File: rtl/nn_weight_loader_if.sv
// Byte stream in, weight write port and status out, for the weight loader.
// Handshake: a byte transfers on any rising clk edge where s_valid && s_ready are both high.
interface nn_weight_loader_if #(
    parameter int CLOG2_MAX_WEIGHTS_N = 2,
    parameter int CLOG2_MAX_WEIGHTS_M = 2
) ();
    logic                           s_valid;
    logic                           s_ready;
    logic [7:0]                     s_data;
    logic                           weights_en;
    logic                           weights_layer_address;
    logic [CLOG2_MAX_WEIGHTS_N-1:0] weights_n_address;
    logic [CLOG2_MAX_WEIGHTS_M-1:0] weights_m_address;
    logic signed [7:0]              weights_data;
    logic                           load_ok;
    logic                           load_err;
    logic                           weights_valid;
    logic                           busy;

    modport slave (
        input  s_valid, s_data,
        output s_ready, weights_en, weights_layer_address, weights_n_address,
               weights_m_address, weights_data, load_ok, load_err, weights_valid, busy
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, weights_en, weights_layer_address, weights_n_address,
               weights_m_address, weights_data, load_ok, load_err, weights_valid, busy
    );
endinterface

// File: rtl/nn_weight_addr_counter.sv
// Nested (layer, n, m) address counter: m is the inner loop, n the outer,
// layer 0 then layer 1. `last` flags the final weight of layer 1.
module nn_weight_addr_counter #(
    parameter int N0 = 3,
    parameter int M0 = 2,
    parameter int N1 = 3,
    parameter int M1 = 1,
    parameter int NW = 2,
    parameter int MW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          advance,
    output logic          layer,
    output logic [NW-1:0] n,
    output logic [MW-1:0] m,
    output logic          last
);
    localparam logic [NW-1:0] N0_LAST = NW'(N0 - 1);
    localparam logic [MW-1:0] M0_LAST = MW'(M0 - 1);
    localparam logic [NW-1:0] N1_LAST = NW'(N1 - 1);
    localparam logic [MW-1:0] M1_LAST = MW'(M1 - 1);

    logic [NW-1:0] n_last;
    logic [MW-1:0] m_last;

    always_comb begin
        n_last = layer ? N1_LAST : N0_LAST;
        m_last = layer ? M1_LAST : M0_LAST;
        last   = layer && (n == N1_LAST) && (m == M1_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            layer <= 1'b0;
            n     <= '0;
            m     <= '0;
        end else if (advance) begin
            if (m == m_last) begin
                m <= '0;
                if (n == n_last) begin
                    n     <= '0;
                    layer <= !layer;
                end else begin
                    n <= n + 1'b1;
                end
            end else begin
                m <= m + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_weight_loader.sv
// Framed byte-stream loader: sync byte, weights in (layer, n, m) order, then a
// checksum byte; each weight byte becomes one registered write on the weights port.
module nn_weight_loader
    import nn_pkg::*;
#(
    parameter int BITS_PER_WORD       = 8,
    parameter int INPUT_VECTOR_SIZE   = 2,
    parameter int HIDDEN_LAYER_SIZE   = 2,
    parameter int OUTPUT_VECTOR_SIZE  = 1,
    parameter int BIAS_SIZE           = 1,
    parameter int CLOG2_MAX_WEIGHTS_N = 2,
    parameter int CLOG2_MAX_WEIGHTS_M = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    nn_weight_loader_if.slave   bus,
    output state_t              state_dbg
);
    localparam int N0 = layer0_n(INPUT_VECTOR_SIZE, BIAS_SIZE);
    localparam int M0 = layer0_m(HIDDEN_LAYER_SIZE);
    localparam int N1 = layer1_n(HIDDEN_LAYER_SIZE, BIAS_SIZE);
    localparam int M1 = layer1_m(OUTPUT_VECTOR_SIZE);

    state_t                         state_q, state_d;
    logic                           xfer;
    logic                           clear_cnt;
    logic                           adv_cnt;
    logic                           cnt_layer;
    logic [CLOG2_MAX_WEIGHTS_N-1:0] cnt_n;
    logic [CLOG2_MAX_WEIGHTS_M-1:0] cnt_m;
    logic                           cnt_last;
    logic [BITS_PER_WORD-1:0]       sum_q;
    logic [BITS_PER_WORD-1:0]       sum_next;

    nn_weight_addr_counter #(
        .N0(N0), .M0(M0), .N1(N1), .M1(M1),
        .NW(CLOG2_MAX_WEIGHTS_N), .MW(CLOG2_MAX_WEIGHTS_M)
    ) u_addr_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_cnt),
        .advance (adv_cnt),
        .layer   (cnt_layer),
        .n       (cnt_n),
        .m       (cnt_m),
        .last    (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        clear_cnt = 1'b0;
        adv_cnt   = 1'b0;
        xfer      = bus.s_valid && bus.s_ready;
        sum_next  = sum_q + bus.s_data;
        case (state_q)
            IDLE: begin
                if (xfer && bus.s_data == SYNC_BYTE) begin
                    clear_cnt = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    adv_cnt = 1'b1;
                    if (cnt_last) state_d = CHECK;
                end
            end
            CHECK: begin
                if (xfer) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The verdict is registered with the checksum transfer so it is visible during DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q                   <= IDLE;
            sum_q                     <= '0;
            bus.s_ready               <= 1'b0;
            bus.weights_en            <= 1'b0;
            bus.weights_layer_address <= 1'b0;
            bus.weights_n_address     <= '0;
            bus.weights_m_address     <= '0;
            bus.weights_data          <= '0;
            bus.load_ok               <= 1'b0;
            bus.load_err              <= 1'b0;
            bus.weights_valid         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus.s_ready    <= (state_d != DONE);
            bus.weights_en <= 1'b0;
            bus.load_ok    <= 1'b0;
            bus.load_err   <= 1'b0;
            if (clear_cnt) begin
                sum_q             <= '0;
                bus.weights_valid <= 1'b0;
            end
            if (state_q == LOAD && xfer) begin
                bus.weights_en            <= 1'b1;
                bus.weights_layer_address <= cnt_layer;
                bus.weights_n_address     <= cnt_n;
                bus.weights_m_address     <= cnt_m;
                bus.weights_data          <= $signed(bus.s_data);
                sum_q                     <= sum_next;
            end
            if (state_q == CHECK && xfer) begin
                sum_q        <= sum_next;
                bus.load_ok  <= (sum_next == '0);
                bus.load_err <= (sum_next != '0);
                if (sum_next == '0) bus.weights_valid <= 1'b1;
            end
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_nn_weight_loader.sv
// Scoreboard bench for nn_weight_loader: a frame-level reference model predicts
// writes and verdicts; a negedge monitor compares them as the DUT presents them.
module tb_nn_weight_loader;
    import nn_pkg::*;

    localparam int IN_SZ  = 2;
    localparam int HID_SZ = 2;
    localparam int OUT_SZ = 1;
    localparam int BIAS   = 1;
    localparam int M0     = HID_SZ;
    localparam int N0     = IN_SZ + BIAS;
    localparam int M1     = OUT_SZ;
    localparam int TOTAL  = (IN_SZ + BIAS) * HID_SZ + (HID_SZ + BIAS) * OUT_SZ;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    logic   mon_en = 1'b0;
    state_t state_dbg;
    int     tests = 0;
    int     fails = 0;

    always #5 clk = ~clk;

    nn_weight_loader_if #(.CLOG2_MAX_WEIGHTS_N(2), .CLOG2_MAX_WEIGHTS_M(2)) bus ();

    nn_weight_loader #(
        .BITS_PER_WORD(8), .INPUT_VECTOR_SIZE(IN_SZ), .HIDDEN_LAYER_SIZE(HID_SZ),
        .OUTPUT_VECTOR_SIZE(OUT_SZ), .BIAS_SIZE(BIAS),
        .CLOG2_MAX_WEIGHTS_N(2), .CLOG2_MAX_WEIGHTS_M(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Expected write = {layer, n[1:0], m[1:0], data[7:0]}; expected verdict = 1 for good.
    logic [12:0] exp_q[$];
    logic        res_q[$];

    // Reference model of the frame parser, in terms of byte positions.
    bit         m_in_frame = 1'b0;
    int         m_idx = 0;
    int         m_sum = 0;
    bit         m_last_good = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] write_of(input int idx, input logic [7:0] b);
        int l, n, m, k;
        if (idx < N0 * M0) begin
            l = 0; n = idx / M0; m = idx % M0;
        end else begin
            k = idx - N0 * M0;
            l = 1; n = k / M1; m = k % M1;
        end
        return {l[0], n[1:0], m[1:0], b};
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame = 1'b1;
                m_idx      = 0;
                m_sum      = 0;
            end
        end else if (m_idx < TOTAL) begin
            exp_q.push_back(write_of(m_idx, b));
            m_sum = (m_sum + int'(b)) % 256;
            m_idx++;
        end else begin
            m_sum       = (m_sum + int'(b)) % 256;
            m_last_good = (m_sum == 0);
            res_q.push_back(m_last_good);
            m_in_frame  = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (bus.weights_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("write", {bus.weights_layer_address, bus.weights_n_address,
                                    bus.weights_m_address, bus.weights_data}, exp_q.pop_front());
                    check("wv_cleared_in_frame", bus.weights_valid, 0);
                end
            end
            if (bus.load_ok || bus.load_err) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    logic r;
                    r = res_q.pop_front();
                    check("load_ok", bus.load_ok, r);
                    check("load_err", bus.load_err, !r);
                    check("wv_at_result", bus.weights_valid, r);
                    check("s_ready_done", bus.s_ready, 0);
                end
            end else begin
                check("s_ready_open", bus.s_ready, 1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        budget = 0;
        while (!bus.s_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.s_ready) begin
            check("s_ready_timeout", 0, 1);
            bus.s_valid = 1'b0;
        end else begin
            model_accept(b);
        end
    endtask

    function automatic logic [7:0] checksum_of(input logic [7:0] w[$]);
        int s;
        s = 0;
        foreach (w[i]) s = (s + int'(w[i])) % 256;
        return 8'((256 - s) % 256);
    endfunction

    task automatic send_frame(input logic [7:0] w[$], input logic [7:0] cks, input int gap_max);
        send_byte(8'hA5);
        foreach (w[i]) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            send_byte(w[i]);
        end
        if (gap_max > 0) idle($urandom_range(0, gap_max));
        send_byte(cks);
        idle(3);
    endtask

    task automatic expect_idle(input logic wv);
        check("busy_after_frame", bus.busy, 0);
        check("weights_valid", bus.weights_valid, wv);
        check("writes_drained", exp_q.size(), 0);
        check("results_drained", res_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.s_valid = 1'b0;
        @(negedge clk);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_weights_en", bus.weights_en, 0);
        check("rst_load_ok", bus.load_ok, 0);
        check("rst_load_err", bus.load_err, 0);
        check("rst_weights_valid", bus.weights_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr_data", {bus.weights_layer_address, bus.weights_n_address,
                                bus.weights_m_address, bus.weights_data}, 0);
        check("rst_state", state_dbg, IDLE);
        check("rst_no_pending_writes", exp_q.size(), 0);
        exp_q.delete();
        res_q.delete();
        m_in_frame  = 1'b0;
        m_last_good = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    initial begin
        logic [7:0] good[$];
        logic [7:0] neg[$];
        logic [7:0] w[$];
        logic [7:0] cks;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        good = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        neg  = '{8'hFF, 8'h80, 8'hA5, 8'h00, 8'h7F, 8'h01, 8'h02, 8'h03, 8'h04};

        do_reset();

        send_frame(good, 8'hD3, 0);
        expect_idle(1);

        send_frame(good, 8'h00, 0);
        expect_idle(0);

        send_byte(8'h11);
        send_byte(8'h22);
        send_frame(good, 8'hD3, 0);
        expect_idle(1);

        send_frame(neg, checksum_of(neg), 0);
        expect_idle(1);

        send_frame(good, 8'hD3, 2);
        expect_idle(1);

        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_byte(good[i]);
        do_reset();
        idle(3);
        check("no_writes_after_reset", exp_q.size(), 0);
        check("wv_after_reset", bus.weights_valid, 0);
        send_frame(good, 8'hD3, 0);
        expect_idle(1);

        for (int f = 0; f < 20; f++) begin
            logic [7:0] g;
            w.delete();
            for (int i = 0; i < TOTAL; i++) w.push_back(8'($urandom_range(0, 255)));
            cks = checksum_of(w);
            if ($urandom_range(0, 3) == 0) cks = cks + 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g);
            end
            send_frame(w, cks, $urandom_range(0, 2));
            expect_idle(m_last_good);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
